// File: rtl/snitch_perf_counters.sv
// snitch_perf_counters: per-core event counters behind a valid/ready register port
//
// Parameters
//   NrCores    : cores whose event strobes are observed
//   NrCounters : independent counters (1..8)
//   CntWidth   : counter width in bits (1..64)
// Ports
//   clk_i, rst_ni             : clock, synchronous active-low reset
//   core_events_i             : per-core event strobes, bit e = event index e
//                               (0 retired_acc, 1 retired_i, 2 retired_load, 3 retired_instr,
//                                4 issue_core_to_fpu, 5 issue_fpu_seq, 6 issue_fpu)
//   req_valid_i / req_ready_o : request handshake
//   req_write_i, req_addr_i, req_wdata_i : request payload
//   rsp_valid_o / rsp_ready_i : response handshake, rsp_rdata_o read data
//   ovf_irq_o                 : overflow interrupt
// Register map: counter k has CTRL at 2k, VALUE at 2k+1.
//   CTRL: [0] enable, [3:1] event, [15:8] hart, [16] sticky overflow, [17] irq enable
// Build option: define SNITCH_PERF_OVF_IRQ_EN to enable the overflow interrupt and CTRL[17].
module snitch_perf_counters #(
    parameter int unsigned NrCores    = 8,
    parameter int unsigned NrCounters = 4,
    parameter int unsigned CntWidth   = 48
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NrCores-1:0][6:0]   core_events_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [3:0]                req_addr_i,
    input  logic [63:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [63:0]               rsp_rdata_o,
    output logic                      ovf_irq_o
);
    logic [NrCores-1:0][6:0]      ev_q;
    logic [CntWidth-1:0]          cnt_q [NrCounters];
    logic [NrCounters-1:0]        en_q, ovf_q, ie_q;
    logic [NrCounters-1:0][2:0]   evt_q;
    logic [NrCounters-1:0][7:0]   hart_q;
    logic [NrCounters-1:0]        hit, wr_ctrl, wr_val, wrap;
    logic [63:0]                  rd_data;
    logic [7:0]                   sel;
    logic                         acc;

    assign req_ready_o = !rsp_valid_o;
    assign acc         = req_valid_i && req_ready_o;

    always_comb begin
        hit     = '0;
        wr_ctrl = '0;
        wr_val  = '0;
        wrap    = '0;
        rd_data = '0;
        sel     = '0;
        for (int k = 0; k < NrCounters; k++) begin
            // Hart indices with no matching core leave sel at 0; bit 7 is always 0 so event 7 never counts.
            sel = '0;
            for (int c = 0; c < NrCores; c++)
                if (hart_q[k] == 8'(c)) sel = {1'b0, ev_q[c]};
            hit[k]     = en_q[k] && sel[evt_q[k]];
            wr_ctrl[k] = acc && req_write_i && req_addr_i == 4'(2*k);
            wr_val[k]  = acc && req_write_i && req_addr_i == 4'(2*k+1);
            // A VALUE write overrides the increment, so it cannot wrap either.
            wrap[k]    = hit[k] && !wr_val[k] && (&cnt_q[k]);
            if (req_addr_i == 4'(2*k))
                rd_data = {46'd0, ie_q[k], ovf_q[k], hart_q[k], 4'd0, evt_q[k], en_q[k]};
            if (req_addr_i == 4'(2*k+1))
                rd_data = 64'(cnt_q[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ev_q        <= '0;
            en_q        <= '0;
            ovf_q       <= '0;
            evt_q       <= '0;
            hart_q      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            for (int k = 0; k < NrCounters; k++) cnt_q[k] <= '0;
        end else begin
            ev_q <= core_events_i;
            for (int k = 0; k < NrCounters; k++) begin
                cnt_q[k] <= wr_val[k] ? req_wdata_i[CntWidth-1:0] : cnt_q[k] + CntWidth'(hit[k]);
                // Sticky: set on wrap (wins over a clear), cleared only by a CTRL write with bit16=0.
                ovf_q[k] <= wrap[k] || (ovf_q[k] && !(wr_ctrl[k] && !req_wdata_i[16]));
                if (wr_ctrl[k]) begin
                    en_q[k]   <= req_wdata_i[0];
                    evt_q[k]  <= req_wdata_i[3:1];
                    hart_q[k] <= req_wdata_i[15:8];
                end
            end
            if (acc) begin
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= req_write_i ? 64'd0 : rd_data;
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

`ifdef SNITCH_PERF_OVF_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ie_q      <= '0;
            ovf_irq_o <= 1'b0;
        end else begin
            for (int k = 0; k < NrCounters; k++)
                if (wr_ctrl[k]) ie_q[k] <= req_wdata_i[17];
            ovf_irq_o <= |(ovf_q & ie_q);
        end
    end
`else
    assign ie_q      = '0;
    assign ovf_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_snitch_perf_counters.sv
// tb_snitch_perf_counters: directed checks of snitch_perf_counters (48-bit and 8-bit instances)
module tb_snitch_perf_counters;
`ifdef SNITCH_PERF_OVF_IRQ_EN
    localparam logic [63:0] IE      = 64'h2_0000;
    localparam logic        IRQ_EXP = 1'b1;
`else
    localparam logic [63:0] IE      = 64'h0;
    localparam logic        IRQ_EXP = 1'b0;
`endif

    typedef struct {
        int          s;
        logic        w;
        logic [3:0]  a;
        logic [63:0] d;
        logic [63:0] e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0][6:0]  ev;
    logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, irq;
    logic             req_write;
    logic [3:0]       req_addr;
    logic [63:0]      req_wdata, rd0, rd1;
    int               n_cmp = 0, n_err = 0;
    vec_t             vecs [16];
    logic [63:0]      r;

    always #5 clk = ~clk;

    snitch_perf_counters dut (
        .clk_i(clk), .rst_ni(rst_n), .core_events_i(ev),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rd0),
        .ovf_irq_o(irq[0])
    );

    snitch_perf_counters #(.CntWidth(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .core_events_i(ev),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rd1),
        .ovf_irq_o(irq[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the response has been consumed.
    task automatic xfer(input int s, input logic w, input logic [3:0] a, input logic [63:0] d,
                        output logic [63:0] rdata);
        int t = 0;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid[s] = 1'b1;
        while (!req_ready[s] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("req_accept_timeout", 64'(t < 20), 64'd1);
        @(negedge clk);
        req_valid[s] = 1'b0;
        chk("rsp_valid", 64'(rsp_valid[s]), 64'd1);
        rdata = s ? rd1 : rd0;
        rsp_ready[s] = 1'b1;
        @(negedge clk);
        rsp_ready[s] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ev = '0; req_valid = '0; rsp_ready = '0;
        req_write = 1'b0; req_addr = '0; req_wdata = '0;
        vecs[0]  = '{0, 1'b1, 4'd3,  64'hDEAD_BEEF_1234_5678, 64'h0};
        vecs[1]  = '{0, 1'b0, 4'd3,  64'h0,                   64'h0000_BEEF_1234_5678};
        vecs[2]  = '{0, 1'b1, 4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[3]  = '{0, 1'b0, 4'd2,  64'h0,                   64'hFF0F | IE};
        vecs[4]  = '{0, 1'b1, 4'd12, 64'h1234,                64'h0};
        vecs[5]  = '{0, 1'b0, 4'd12, 64'h0,                   64'h0};
        vecs[6]  = '{0, 1'b0, 4'd15, 64'h0,                   64'h0};
        vecs[7]  = '{0, 1'b1, 4'd0,  64'h7,                   64'h0};
        vecs[8]  = '{0, 1'b0, 4'd0,  64'h0,                   64'h7};
        vecs[9]  = '{0, 1'b1, 4'd4,  64'h907,                 64'h0};
        vecs[10] = '{0, 1'b1, 4'd5,  64'h55,                  64'h0};
        vecs[11] = '{0, 1'b1, 4'd6,  64'h000F,                64'h0};
        vecs[12] = '{0, 1'b1, 4'd7,  64'h66,                  64'h0};
        vecs[13] = '{1, 1'b1, 4'd3,  64'h1FE,                 64'h0};
        vecs[14] = '{1, 1'b0, 4'd3,  64'h0,                   64'hFE};
        vecs[15] = '{1, 1'b1, 4'd2,  64'h2_0203,              64'h0};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_rsp_valid", 64'(rsp_valid[s]), 64'd0);
            chk("rst_req_ready", 64'(req_ready[s]), 64'd1);
            chk("rst_irq", 64'(irq[s]), 64'd0);
        end
        chk("rst_rdata0", rd0, 64'd0);
        chk("rst_rdata1", rd1, 64'd0);

        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, r);
            chk($sformatf("vec%0d", i), r, vecs[i].e);
        end
        xfer(1, 1'b0, 4'd2, 64'h0, r);
        chk("ctrl1_8b", r, 64'h203 | IE);

        // Five retired_instr strobes on core 0
        for (int i = 0; i < 5; i++) begin
            ev[0] = 7'b000_1000;
            @(negedge clk);
        end
        ev = '0;
        repeat (3) @(negedge clk);
        xfer(0, 1'b0, 4'd1, 64'h0, r);
        chk("count5", r, 64'd5);

        // Three retired_i strobes on hart 2 wrap the 8-bit counter from 0xFE
        for (int i = 0; i < 3; i++) begin
            ev[2] = 7'b000_0010;
            @(negedge clk);
        end
        ev = '0;
        repeat (3) @(negedge clk);
        chk("wrap_irq", 64'(irq[1]), 64'(IRQ_EXP));
        xfer(1, 1'b0, 4'd3, 64'h0, r);
        chk("wrap_value", r, 64'h01);
        xfer(1, 1'b0, 4'd2, 64'h0, r);
        chk("wrap_ctrl", r, 64'h1_0203 | IE);
        xfer(1, 1'b1, 4'd2, 64'h3_0203, r);
        xfer(1, 1'b0, 4'd2, 64'h0, r);
        chk("ovf_keep", r, 64'h1_0203 | IE);
        xfer(1, 1'b1, 4'd2, 64'h2_0203, r);
        repeat (2) @(negedge clk);
        chk("ovf_clr_irq", 64'(irq[1]), 64'd0);
        xfer(1, 1'b0, 4'd2, 64'h0, r);
        chk("ovf_clr", r, 64'h203 | IE);

        // VALUE write lands on the same edge as a counted increment
        ev[0] = 7'b000_1000;
        @(negedge clk);
        ev = '0;
        xfer(0, 1'b1, 4'd1, 64'h100, r);
        xfer(0, 1'b0, 4'd1, 64'h0, r);
        chk("write_wins", r, 64'h100);

        // Every strobe active: hart 9 and event 7 counters stay put, counter 0 advances by 4
        for (int i = 0; i < 4; i++) begin
            ev = '1;
            @(negedge clk);
        end
        ev = '0;
        repeat (3) @(negedge clk);
        xfer(0, 1'b0, 4'd5, 64'h0, r);
        chk("hart9_idle", r, 64'h55);
        xfer(0, 1'b0, 4'd7, 64'h0, r);
        chk("evt7_idle", r, 64'h66);
        xfer(0, 1'b0, 4'd3, 64'h0, r);
        chk("evt7_hartff_idle", r, 64'h0000_BEEF_1234_5678);
        xfer(0, 1'b0, 4'd15, 64'h0, r);
        chk("addr15", r, 64'h0);

        // Response back-pressure with a competing request held valid
        req_write = 1'b0; req_addr = 4'd1; req_valid[0] = 1'b1;
        @(negedge clk);
        req_addr = 4'd5;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_valid%0d", i), 64'(rsp_valid[0]), 64'd1);
            chk($sformatf("bp_rdata%0d", i), rd0, 64'h104);
            chk($sformatf("bp_ready%0d", i), 64'(req_ready[0]), 64'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0; rsp_ready[0] = 1'b0;
        chk("bp_done", 64'(rsp_valid[0]), 64'd0);
        @(negedge clk);
        chk("bp_no_accept", 64'(rsp_valid[0]), 64'd0);

        // One-cycle reset with a response pending
        req_addr = 4'd1; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("pend_valid", 64'(rsp_valid[0]), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst2_rdata", rd0, 64'd0);
        chk("rst2_ready", 64'(req_ready[0]), 64'd1);
        chk("rst2_irq", 64'(irq[1]), 64'd0);
        xfer(0, 1'b0, 4'd1, 64'h0, r);
        chk("rst2_value0", r, 64'd0);
        xfer(0, 1'b0, 4'd0, 64'h0, r);
        chk("rst2_ctrl0", r, 64'd0);
        xfer(1, 1'b0, 4'd3, 64'h0, r);
        chk("rst2_value1_8b", r, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/snitch_perf_counters.md
SNITCH_PERF_COUNTERS -- requirements
Module: snitch_perf_counters

Interface
REQ-001 SHALL have parameter NrCores, default 8, number of cores whose core_events_t strobes are observed.
REQ-002 SHALL have parameter NrCounters, default 4, number of independent counters (1..8).
REQ-003 SHALL have parameter CntWidth, default 48, counter width in bits (1..64).
REQ-004 SHALL have port clk_i  input  1  sole clock.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port core_events_i  input  NrCores x core_events_t  per-core event strobes, one cycle each.
REQ-007 SHALL have ports req_valid_i/req_ready_o  in/out  1  request handshake.
REQ-008 SHALL have ports req_write_i  in  1, req_addr_i  in  4, req_wdata_i  in  64  request payload.
REQ-009 SHALL have ports rsp_valid_o/rsp_ready_i  out/in  1  response handshake, and rsp_rdata_o  out  64.
REQ-010 SHALL have port ovf_irq_o  output  1  overflow interrupt (see Configuration).

Function
REQ-011 SHALL map counter k to CTRL at address 2k and VALUE at address 2k+1; addresses >= 2*NrCounters read 0, writes ignored.
REQ-012 SHALL define CTRL as: bit0 enable, bits[3:1] event index, bits[15:8] hart index, bit16 sticky overflow, bit17 irq enable; other bits read 0.
REQ-013 SHALL select event index e as bit e of packed core_events_t: 0 retired_acc, 1 retired_i, 2 retired_load, 3 retired_instr, 4 issue_core_to_fpu, 5 issue_fpu_seq, 6 issue_fpu; 7 counts nothing.
REQ-014 SHALL count nothing when hart index >= NrCores.
REQ-015 SHALL register core_events_i once; a strobe in cycle t increments an enabled counter at the edge ending cycle t+1, by exactly 1.
REQ-016 SHALL wrap VALUE modulo 2^CntWidth and set CTRL bit16 on the wrap increment.
REQ-017 SHALL clear bit16 only by a CTRL write with bit16=0; a CTRL write with bit16=1 leaves bit16 unchanged.
REQ-018 SHALL give a VALUE write precedence over a same-cycle increment; written value is req_wdata_i[CntWidth-1:0].
REQ-019 SHALL give a wrap in the same cycle as a CTRL write clearing bit16 precedence (bit16 set).
REQ-020 SHALL drive req_ready_o = !rsp_valid_o (one outstanding transaction).
REQ-021 SHALL, on request acceptance at edge t, perform the write or capture read data at that edge and assert rsp_valid_o from cycle t+1 until rsp_ready_i is sampled high.
REQ-022 SHALL hold rsp_rdata_o stable while rsp_valid_o is high; read data zero-extended to 64 bits; write responses return 0.
REQ-023 SHALL return for a VALUE read the counter value before any increment at the accepting edge.

Reset
REQ-024 SHALL reset all counters, all CTRL fields, the event register, rsp_valid_o, rsp_rdata_o and ovf_irq_o to 0.
REQ-025 SHALL abandon any pending response on reset; req_ready_o is 1 in the first cycle after reset deassertion.

Configuration
REQ-026 SHALL, with SNITCH_PERF_OVF_IRQ_EN defined, register ovf_irq_o = OR over k of (CTRL_k bit16 AND bit17), one cycle after the bits change.
REQ-027 SHALL, without SNITCH_PERF_OVF_IRQ_EN, tie ovf_irq_o to 0, make CTRL bit17 read 0 and ignore writes to it; bit16 still functions.

Verification
REQ-028 SHALL cover: write CTRL0=0x0007 (enable, event 3, hart 0), pulse retired_instr of core 0 for 5 cycles -> VALUE0 read returns 5.
REQ-029 SHALL cover: CntWidth=8, VALUE1=0xFE, CTRL1 enabled on retired_i hart 2, 3 strobes -> VALUE1=0x01, CTRL1 bit16=1, ovf_irq_o=1 (macro on, bit17 set) or 0 (macro off).
REQ-030 SHALL cover: VALUE write 0x100 in the same cycle as a counted increment -> VALUE reads 0x100.
REQ-031 SHALL cover: rsp_ready_i held low 4 cycles after a read -> rsp_valid_o and rsp_rdata_o stable, req_ready_o=0, new req_valid_i not accepted.
REQ-032 SHALL cover: hart index 9 with NrCores=8, or event index 7, all strobes active -> VALUE unchanged; read of address 15 -> 0.
REQ-033 SHALL cover: rst_ni low for one cycle with a response pending and counters nonzero -> all outputs and counters 0, req_ready_o=1 next cycle.
